// File: rtl/mul5_encoder_if.sv
// rtl/mul5_encoder_if.sv - input word, serial tap and result handshake bundle for mul5_encoder
interface mul5_encoder_if #(parameter int W = 6);
   logic [W-1:0] din;
   logic         in_valid;
   logic         in_ready;
   logic         ser_bit;
   logic         ser_valid;
   logic [W-1:0] dout;
   logic [2:0]   rem;
   logic         out_valid;
   logic         out_ready;

   modport master (
      output din, in_valid, out_ready,
      input  in_ready, ser_bit, ser_valid, dout, rem, out_valid
   );

   modport slave (
      input  din, in_valid, out_ready,
      output in_ready, ser_bit, ser_valid, dout, rem, out_valid
   );
endinterface

// File: rtl/mul5_encoder.sv
// rtl/mul5_encoder.sv - rounds a W-bit word down to a multiple of 5, walking it MSB-first
// with a mod-5 remainder FSM and exposing each bit on a serial tap.
module mul5_encoder #(
   parameter int W = 6
) (
   input  logic          clk,
   input  logic          rst,
   mul5_encoder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, SUB, HOLD} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] data_q;
   logic [W-1:0] shreg_q;
   logic [W-1:0] dout_q;
   logic [4:0]   cnt_q;
   logic [2:0]   r_q;
   logic [2:0]   rem_q;
   logic [2:0]   r_step;
   logic [3:0]   r_ext;
   logic         last_bit;

   // {r, bit} is at most 9, so one conditional subtract keeps it mod 5
   always_comb begin
      r_ext    = {r_q, shreg_q[W-1]};
      r_step   = r_ext[2:0];
      if (r_ext >= 4'd5) begin
         r_step = 3'(r_ext - 4'd5);
      end
      last_bit = (cnt_q == 5'(W - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = SHIFT;
         SHIFT:   if (last_bit)      state_d = SUB;
         SUB:                        state_d = HOLD;
         HOLD:    if (bus.out_ready) state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         shreg_q <= '0;
         cnt_q   <= '0;
         r_q     <= '0;
         dout_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q  <= bus.din;
                  shreg_q <= bus.din;
                  cnt_q   <= '0;
                  r_q     <= '0;
               end
            end
            SHIFT: begin
               r_q     <= r_step;
               shreg_q <= {shreg_q[W-2:0], 1'b0};
               cnt_q   <= cnt_q + 5'd1;
            end
            SUB: begin
               // r never exceeds data_q, so this cannot wrap
               dout_q <= data_q - W'(r_q);
               rem_q  <= r_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.ser_valid = (state_q == SHIFT);
   assign bus.ser_bit   = (state_q == SHIFT) ? shreg_q[W-1] : 1'b0;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.dout      = dout_q;
   assign bus.rem       = rem_q;
endmodule

// File: tb/tb_mul5_encoder.sv
// tb/tb_mul5_encoder.sv - directed bench for mul5_encoder with serial-bit and result scoreboards
module tb_mul5_encoder;
   localparam int W = 6;

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic [2:0]   rem;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   logic ser_q[$];
   exp_t out_q[$];
   logic ser_e;
   exp_t out_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul5_encoder_if #(.W(W)) bus();

   mul5_encoder #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.ser_valid) begin
            check("ser_expected", 32'(ser_q.size() > 0), 1);
            if (ser_q.size() > 0) begin
               ser_e = ser_q.pop_front();
               check("ser_bit", 32'(bus.ser_bit), 32'(ser_e));
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            check("out_expected", 32'(out_q.size() > 0), 1);
            if (out_q.size() > 0) begin
               out_e = out_q.pop_front();
               check("dout", 32'(bus.dout), 32'(out_e.dout));
               check("rem", 32'(bus.rem), 32'(out_e.rem));
               check("detect_mul5", 32'((bus.dout % 5) == 0), 1);
               check("din_minus_dout", 32'(out_e.din - bus.dout), 32'(bus.rem));
            end
         end
      end
   end

   task automatic push_expect(input logic [W-1:0] d);
      exp_t e;
      for (int i = W - 1; i >= 0; i--) ser_q.push_back(d[i]);
      e.din  = d;
      e.dout = W'(d - d % 5);
      e.rem  = 3'(d % 5);
      out_q.push_back(e);
   endtask

   task automatic send_word(input logic [W-1:0] d, output int acc_cyc);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.in_ready && n < 200);
      check("in_ready_wait", 32'(bus.in_ready), 1);
      bus.din      = d;
      bus.in_valid = 1'b1;
      push_expect(d);
      @(posedge clk); #1;
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((out_q.size() != 0 || !bus.in_ready) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_out_q", out_q.size(), 0);
      check("drain_ser_q", ser_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a, prev, k, stray;

      rst           = 1'b1;
      bus.din       = 6'd37;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;

      // reset held two cycles with in_valid asserted
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_in_ready", 32'(bus.in_ready), 1);
         check("rst_out_valid", 32'(bus.out_valid), 0);
         check("rst_ser_valid", 32'(bus.ser_valid), 0);
         check("rst_dout", 32'(bus.dout), 0);
         check("rst_rem", 32'(bus.rem), 0);
      end

      // release reset; first word accepted on the next edge
      rst = 1'b0;
      push_expect(6'd37);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      k = 1;
      while (!bus.out_valid && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency_out_valid", k, W + 2);
      check("first_dout", 32'(bus.dout), 35);
      check("first_rem", 32'(bus.rem), 2);
      drain();

      // boundary values
      send_word(6'd0, a);
      send_word(6'd5, a);
      send_word(6'd63, a);
      send_word(6'd4, a);
      drain();

      // backpressure
      bus.out_ready = 1'b0;
      send_word(6'd23, a);
      k = 0;
      while (!bus.out_valid && k < 30) begin
         @(posedge clk); #1;
         k++;
      end
      for (int i = 0; i < 10; i++) begin
         check("bp_out_valid", 32'(bus.out_valid), 1);
         check("bp_dout", 32'(bus.dout), 20);
         check("bp_rem", 32'(bus.rem), 3);
         check("bp_in_ready", 32'(bus.in_ready), 0);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_out_valid", 32'(bus.out_valid), 0);
      check("bp_release_in_ready", 32'(bus.in_ready), 1);
      drain();

      // input offered while busy must be ignored
      send_word(6'd7, a);
      @(posedge clk); #1;
      bus.din      = 6'd50;
      bus.in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      drain();
      send_word(6'd50, a);
      drain();

      // reset on the third SHIFT cycle discards the word
      send_word(6'd44, a);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ser_q.delete();
      out_q.delete();
      check("midrst_in_ready", 32'(bus.in_ready), 1);
      check("midrst_ser_valid", 32'(bus.ser_valid), 0);
      check("midrst_out_valid", 32'(bus.out_valid), 0);
      check("midrst_rem", 32'(bus.rem), 0);
      stray = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus.out_valid || bus.ser_valid) stray++;
      end
      check("midrst_no_output", stray, 0);

      // exhaustive back-to-back sweep
      prev = 0;
      for (int d = 0; d < (1 << W); d++) begin
         send_word(W'(d), a);
         if (d > 0) check("sweep_period", a - prev, W + 3);
         prev = a;
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mul5_encoder.md
Name: mul5_encoder

Overview:
- Encoder counterpart of the 6-bit multiple-of-5 detector. It accepts an arbitrary W-bit word and produces the largest multiple of 5 that is ≤ the input, plus the discarded remainder.
- Walks the input MSB-first, one bit per clock, with a 5-state remainder FSM. It emits each bit on a serial tap as it goes, then subtracts the remainder.
- Sits ahead of the detector in the test datapath, so every word it emits must be flagged as a multiple of 5 downstream.

Parameters:
- W, 6, data width in bits (legal range 3..16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  W  input word, sampled on the accept cycle.
- in_valid  input  1  din is valid.
- in_ready  output  1  block can accept a word (high only in IDLE).
- ser_bit  output  1  input bit currently being processed, MSB-first.
- ser_valid  output  1  ser_bit is valid (high for exactly W cycles per word).
- dout  output  W  din minus (din mod 5).
- rem  output  3  din mod 5, range 0..4.
- out_valid  output  1  dout/rem are valid.
- out_ready  input  1  downstream accepts dout/rem.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; the shift register, bit counter and remainder are cleared.
  - in_ready=1; ser_bit, ser_valid, out_valid, dout and rem are all 0.
  - Reset overrides every other input, including mid-SHIFT or mid-HOLD; any word in progress is discarded with no output.
- FSM states: IDLE, SHIFT, SUB, HOLD.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch din into data_q and a shift register, clear remainder r and bit counter, go to SHIFT.
  - in_valid=0 keeps the block in IDLE.
- SHIFT (exactly W cycles):
  - in_ready=0; in_valid is ignored and the word is not queued.
  - Each cycle: ser_bit = current MSB of the shift register, ser_valid=1.
  - At the edge: r <= (2*r + ser_bit) mod 5, computed as the 4-bit value {r, bit}, subtracting 5 if ≥5 (value never exceeds 9); then shift left and increment the counter.
  - After the W-th bit, go to SUB.
- SUB (1 cycle):
  - ser_valid=0.
  - At the edge: dout <= data_q − r, W-bit unsigned, which never underflows because r ≤ data_q; rem <= r.
  - Go to HOLD.
- HOLD:
  - out_valid=1; dout and rem are held stable until the handshake.
  - On an edge with out_ready=1: out_valid drops and the state goes to IDLE.
  - in_ready is 0 in HOLD, so no input is accepted in the handshake cycle.
- Latency:
  - Accept edge at cycle 0; ser_valid is high during cycles 1..W; out_valid rises at cycle W+2.
  - Minimum word-to-word period is W+3 cycles when out_ready is held at 1.
- Handshake rules:
  - out_valid, once high, may fall only after an out_ready handshake or reset.
  - dout and rem change only at SUB and reset; after the handshake they retain their last value.
- Invariants:
  - dout mod 5 == 0, dout ≤ din, and din − dout == rem ∈ [0,4].
  - Boundary: din=0 gives dout=0, rem=0. din = all-ones (63 for W=6) gives dout=60, rem=3.

Test Plan:
- Reset, then one word: rst=1 for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, dout=0, rem=0, no ser_valid pulses. Release rst with din=6'd37, in_valid=1, out_ready=1 → ser_bit sequence 1,0,0,1,0,1 over 6 cycles; out_valid at cycle 8 with dout=35, rem=2.
- Boundary values: din=0 → dout=0, rem=0; din=5 → dout=5, rem=0; din=63 → dout=60, rem=3; din=4 → dout=0, rem=4.
- Backpressure: din=23, out_ready=0 for 10 cycles → out_valid stays 1 with dout=20, rem=3 stable and in_ready=0; then out_ready=1 for one cycle → out_valid=0, in_ready=1 the next cycle.
- Busy input ignored: during SHIFT, in_valid=1 with din=50 → word not accepted; the result is the first word's only. A fresh in_valid after returning to IDLE yields dout=50, rem=0.
- Reset mid-operation: rst=1 on the 3rd SHIFT cycle → next cycle IDLE, ser_valid=0, out_valid=0, rem=0, and no output is ever produced for that word.
- Exhaustive sweep, W=6: din=0..63 back-to-back with out_ready=1 → for every word dout%5==0, din−dout==rem, and the downstream detector asserts its match output; throughput is one word per 9 cycles.
